m_dm_ctrl: RTL and testbench

//  M-stage data-memory access controller. Accepts one load/store per request from the M stage,

---
 rtl/m_dm_ctrl_pkg.sv | 39 +++
 rtl/m_dm_lane.sv | 47 ++++
 rtl/m_dm_ctrl.sv | 155 +++++++++++++++
 tb/tb_m_dm_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_dm_ctrl_pkg.sv
// Shared definitions for the M-stage data-memory controller: op codes, exception codes,
// FSM state encoding and small op-classification helpers.
package m_dm_ctrl_pkg;

    localparam logic [2:0] MEM_NOP = 3'b000;
    localparam logic [2:0] MEM_LW  = 3'b001;
    localparam logic [2:0] MEM_LH  = 3'b010;
    localparam logic [2:0] MEM_LB  = 3'b011;
    localparam logic [2:0] MEM_SW  = 3'b100;
    localparam logic [2:0] MEM_SH  = 3'b101;
    localparam logic [2:0] MEM_SB  = 3'b110;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_ADEL = 2'd1;
    localparam logic [1:0] EXC_ADES = 2'd2;
    localparam logic [1:0] EXC_TMO  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } dm_state_e;

    function automatic logic is_load(input logic [2:0] op);
        return (op == MEM_LW) || (op == MEM_LH) || (op == MEM_LB);
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
        if (op == MEM_LW || op == MEM_SW) return off != 2'b00;
        if (op == MEM_LH || op == MEM_SH) return off[0];
        return 1'b0;
    endfunction

endpackage

// File: rtl/m_dm_lane.sv
// Combinational lane steering: store byte enables and replicated write data, and
// sign extension of the addressed byte/half of a raw load word.
module m_dm_lane
    import m_dm_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byteen,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    always_comb begin
        half     = off[1] ? rdata[31:16] : rdata[15:0];
        byte_sel = rdata[8*off +: 8];
    end

    always_comb begin
        byteen     = 4'b0000;
        lane_wdata = '0;
        load_data  = '0;
        case (op)
            MEM_SW: begin
                byteen     = 4'b1111;
                lane_wdata = wdata;
            end
            MEM_SH: begin
                byteen     = 4'b0011 << {off[1], 1'b0};
                lane_wdata = {2{wdata[15:0]}};
            end
            MEM_SB: begin
                byteen     = 4'b0001 << off;
                lane_wdata = {4{wdata[7:0]}};
            end
            MEM_LW: load_data = rdata;
            MEM_LH: load_data = {{16{half[15]}}, half};
            MEM_LB: load_data = {{24{byte_sel[7]}}, byte_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/m_dm_ctrl.sv
// M-stage data-memory access controller: validates one load/store, runs the req/gnt/rvalid
// handshake with a timeout, stalls the pipeline and returns a one-cycle response pulse.
module m_dm_ctrl
    import m_dm_ctrl_pkg::*;
#(
    parameter logic [31:0] DM_BASE = 32'h0000_0000,
    parameter logic [31:0] DM_SIZE = 32'h0000_3000,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_exc,
    output logic        m_data_req,
    output logic        m_data_wr,
    output logic [31:0] m_data_addr,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_data_wdata,
    input  logic        m_data_gnt,
    input  logic        m_data_rvalid,
    input  logic [31:0] m_data_rdata
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    dm_state_e       state_q;
    logic [2:0]      op_q;
    logic [1:0]      off_q;
    logic [CntW-1:0] cnt_q;

    logic [2:0]  lane_op;
    logic [1:0]  lane_off;
    logic [3:0]  lane_byteen;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;
    logic [32:0] win_off;
    logic        req_bad;
    logic        timed_out;

    // Lane logic sees the incoming request while idle and the latched one afterwards.
    assign lane_op  = (state_q == StIdle) ? req_op : op_q;
    assign lane_off = (state_q == StIdle) ? req_addr[1:0] : off_q;

    m_dm_lane u_lane (
        .op         (lane_op),
        .off        (lane_off),
        .wdata      (req_wdata),
        .rdata      (m_data_rdata),
        .byteen     (lane_byteen),
        .lane_wdata (lane_wdata),
        .load_data  (lane_load)
    );

    // A borrow out of the subtraction means the address lies below the window.
    assign win_off   = {1'b0, req_addr} - {1'b0, DM_BASE};
    assign req_bad   = misaligned(req_op, req_addr[1:0]) || win_off[32] ||
                       (win_off[31:0] >= DM_SIZE);
    assign timed_out = cnt_q >= CntLast;

    assign stall = ((state_q == StIdle) && req_valid) || (state_q == StIssue) ||
                   (state_q == StWait);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            op_q          <= MEM_NOP;
            off_q         <= '0;
            cnt_q         <= '0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_exc       <= EXC_NONE;
            m_data_req    <= 1'b0;
            m_data_wr     <= 1'b0;
            m_data_addr   <= '0;
            m_data_byteen <= '0;
            m_data_wdata  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        off_q <= req_addr[1:0];
                        if (!is_load(req_op) && !is_store(req_op)) begin
                            state_q   <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_exc   <= EXC_NONE;
                        end else if (req_bad) begin
                            state_q   <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_exc   <= is_load(req_op) ? EXC_ADEL : EXC_ADES;
                        end else begin
                            state_q       <= StIssue;
                            cnt_q         <= '0;
                            m_data_req    <= 1'b1;
                            m_data_wr     <= is_store(req_op);
                            m_data_addr   <= {req_addr[31:2], 2'b00};
                            m_data_byteen <= lane_byteen;
                            m_data_wdata  <= lane_wdata;
                        end
                    end
                end
                StIssue: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (m_data_gnt || timed_out) begin
                        m_data_req    <= 1'b0;
                        m_data_wr     <= 1'b0;
                        m_data_addr   <= '0;
                        m_data_byteen <= '0;
                        m_data_wdata  <= '0;
                    end
                    // Completing on the last allowed cycle wins over the timeout.
                    if (m_data_gnt && (is_store(op_q) || m_data_rvalid)) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= is_store(op_q) ? '0 : lane_load;
                        rsp_exc   <= EXC_NONE;
                    end else if (timed_out) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_exc   <= EXC_TMO;
                    end else if (m_data_gnt) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (m_data_rvalid) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= lane_load;
                        rsp_exc   <= EXC_NONE;
                    end else if (timed_out) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_exc   <= EXC_TMO;
                    end
                end
                StResp: begin
                    state_q   <= StIdle;
                    rsp_rdata <= '0;
                    rsp_exc   <= EXC_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_dm_ctrl.sv
// Randomized self-checking bench for m_dm_ctrl against a cycle-level behavioural model
// of request validation, lane steering, load extension, latency and timeout.
module tb_m_dm_ctrl;

    localparam int TMO   = 8;
    localparam int NEVER = 255;
    localparam logic [31:0] X_NONE = 32'd0;
    localparam logic [31:0] X_ADEL = 32'd1;
    localparam logic [31:0] X_ADES = 32'd2;
    localparam logic [31:0] X_TMO  = 32'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_exc;
    logic        m_data_req;
    logic        m_data_wr;
    logic [31:0] m_data_addr;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_wdata;
    logic        m_data_gnt;
    logic        m_data_rvalid;
    logic [31:0] m_data_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m_dm_ctrl #(
        .DM_BASE (32'h0000_0000),
        .DM_SIZE (32'h0000_3000),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .stall         (stall),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_exc       (rsp_exc),
        .m_data_req    (m_data_req),
        .m_data_wr     (m_data_wr),
        .m_data_addr   (m_data_addr),
        .m_data_byteen (m_data_byteen),
        .m_data_wdata  (m_data_wdata),
        .m_data_gnt    (m_data_gnt),
        .m_data_rvalid (m_data_rvalid),
        .m_data_rdata  (m_data_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext_load(input int op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int unsigned sh = 8 * (addr % 4);
        logic [31:0] v;
        if (op == 1) return rd;
        if (op == 2) begin
            v = (rd >> sh) & 32'hFFFF;
            return (v >= 32'h8000) ? v - 32'h1_0000 : v;
        end
        v = (rd >> sh) & 32'hFF;
        return (v >= 32'h80) ? v - 32'h100 : v;
    endfunction

    // Called at a falling edge with the controller idle; returns at a falling edge.
    task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                          input int gdly, input int rdly, input logic [31:0] rd);
        bit          is_ld = (op >= 1 && op <= 3);
        bit          is_st = (op >= 4 && op <= 6);
        int unsigned size  = (op == 1 || op == 4) ? 4 : ((op == 2 || op == 5) ? 2 : 1);
        bit          issue = 0;
        int          gcyc  = 1 << 20;
        int          cc;
        int          exp_lat = 1;
        logic [31:0] exp_exc = X_NONE;
        logic [31:0] exp_rd  = 32'd0;
        logic [31:0] exp_be;
        logic [31:0] exp_wd;
        int          c;
        bit          done = 0;

        if (is_ld || is_st) begin
            if ((addr % size) != 0 || addr >= 32'h3000) begin
                exp_exc = is_ld ? X_ADEL : X_ADES;
            end else begin
                issue = 1;
                if (gdly != NEVER) gcyc = 1 + gdly;
                cc = is_st ? gcyc : ((rdly == NEVER) ? (1 << 20) : gcyc + rdly);
                if (cc <= TMO) begin
                    exp_lat = cc + 1;
                    exp_rd  = is_ld ? ext_load(op, addr, rd) : 32'd0;
                end else begin
                    exp_lat = TMO + 1;
                    exp_exc = X_TMO;
                end
            end
        end
        exp_be = is_st ? (((32'd1 << size) - 32'd1) << (addr % 4)) : 32'd0;
        exp_wd = (size == 4) ? wdata :
                 (size == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 :
                               (wdata & 32'hFF) * 32'h0101_0101;

        req_valid = 1'b1;
        req_op    = 3'(op);
        req_addr  = addr;
        req_wdata = wdata;
        #1 check("stall_accept", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom_range(0, 7));
        req_addr  = $urandom;
        req_wdata = $urandom;
        @(negedge clk);
        c = 1;
        while (!done && c <= TMO + 4) begin
            if (rsp_valid) begin
                done = 1;
                check("latency", 32'(c), 32'(exp_lat));
                check("rsp_rdata", rsp_rdata, exp_rd);
                check("rsp_exc", 32'(rsp_exc), exp_exc);
                check("rsp_req_low", 32'(m_data_req), 32'd0);
                check("rsp_stall_low", 32'(stall), 32'd0);
            end else begin
                check("stall_busy", 32'(stall), 32'd1);
                check("req_level", 32'(m_data_req), 32'(issue && c <= gcyc && c <= TMO));
                if (m_data_req) begin
                    check("bus_addr", m_data_addr, addr & 32'hFFFF_FFFC);
                    check("bus_wr", 32'(m_data_wr), 32'(is_st));
                    check("bus_byteen", 32'(m_data_byteen), exp_be);
                    if (is_st) check("bus_wdata", m_data_wdata, exp_wd);
                end
                m_data_gnt = issue && c == gcyc && c <= TMO;
                if (is_ld && issue && rdly != NEVER && c == gcyc + rdly) begin
                    m_data_rvalid = 1'b1;
                    m_data_rdata  = rd;
                end else begin
                    // Stray rvalid where the controller must ignore it.
                    m_data_rvalid = (!is_ld || c < gcyc) && ($urandom_range(0, 3) == 0);
                    m_data_rdata  = $urandom;
                end
                @(negedge clk);
                c++;
            end
        end
        if (!done) check("rsp_seen", 32'd0, 32'd1);
        m_data_gnt    = 1'($urandom_range(0, 1));
        m_data_rvalid = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("idle_rsp", 32'(rsp_valid), 32'd0);
        check("idle_req", 32'(m_data_req), 32'd0);
        check("idle_stall", 32'(stall), 32'd0);
        m_data_gnt    = 1'b0;
        m_data_rvalid = 1'b0;
    endtask

    initial begin
        int          op;
        int          sel;
        logic [31:0] addr;
        int          gd;
        int          rv;

        reset         = 1'b0;
        req_valid     = 1'b0;
        req_op        = 3'd0;
        req_addr      = 32'd0;
        req_wdata     = 32'd0;
        m_data_gnt    = 1'b0;
        m_data_rvalid = 1'b0;
        m_data_rdata  = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_exc", 32'(rsp_exc), 32'd0);
        check("rst_req", 32'(m_data_req), 32'd0);
        check("rst_wr", 32'(m_data_wr), 32'd0);
        check("rst_addr", m_data_addr, 32'd0);
        check("rst_byteen", 32'(m_data_byteen), 32'd0);
        check("rst_wdata", m_data_wdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op(4, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'd0);
        run_op(6, 32'h13, 32'h0000_00A5, 1, 0, 32'd0);
        run_op(5, 32'h12, 32'h1234_BEEF, 0, 0, 32'd0);
        run_op(3, 32'h21, 32'd0, 0, 3, 32'h1234_80FF);
        run_op(2, 32'h22, 32'd0, 2, 1, 32'h8001_7FFF);
        run_op(1, 32'h6, 32'd0, 0, 0, 32'd0);
        run_op(4, 32'h3000, 32'h1111_2222, 0, 0, 32'd0);
        run_op(4, 32'h40, 32'h5555_AAAA, NEVER, 0, 32'd0);
        run_op(1, 32'h44, 32'd0, 0, NEVER, 32'hFFFF_FFFF);
        run_op(1, 32'h48, 32'd0, 0, 0, 32'hCAFE_F00D);
        run_op(4, 32'h2FFC, 32'h0102_0304, 0, 0, 32'd0);
        run_op(0, 32'h4, 32'd0, 0, 0, 32'd0);
        run_op(7, 32'h3, 32'd0, 0, 0, 32'd0);

        // Asynchronous reset while a load waits for read data.
        req_valid = 1'b1;
        req_op    = 3'd1;
        req_addr  = 32'h80;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        m_data_gnt = 1'b1;
        @(negedge clk);
        m_data_gnt = 1'b0;
        check("wait_stall", 32'(stall), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_req", 32'(m_data_req), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        m_data_rvalid = 1'b1;
        m_data_rdata  = 32'h7777_7777;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("late_rvalid_rsp", 32'(rsp_valid), 32'd0);
            check("late_rvalid_stall", 32'(stall), 32'd0);
        end
        m_data_rvalid = 1'b0;
        run_op(2, 32'h82, 32'd0, 1, 2, 32'h0000_1234);

        for (int i = 0; i < 200; i++) begin
            op  = $urandom_range(0, 7);
            sel = $urandom_range(0, 7);
            case (sel)
                0:       addr = 32'h2FFC + $urandom_range(0, 3);
                1:       addr = 32'h3000 + $urandom_range(0, 7);
                2:       addr = $urandom;
                default: addr = $urandom_range(0, 32'h2FFF);
            endcase
            gd = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 3);
            rv = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 9);
            run_op(op, addr, $urandom, gd, rv, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
